fifo_ctrl: RTL and testbench

//   Single-clock FIFO controller that sequences a fifo_memory instance (1-cycle registered read,

---
 rtl/fifo_ctrl.sv | 93 +++++++++
 tb/tb_fifo_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external 1-cycle registered-read memory.
// Optional registered watermarks are enabled by defining FIFO_CTRL_WATERMARK_EN.
module fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AF_LEVEL   = 28,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
`ifdef FIFO_CTRL_WATERMARK_EN
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
`endif
  output logic                  o_empty
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] ram_cnt;
  logic             head_vld;
  logic             push;
  logic             pop;
  logic             rd_en;

  // Occupancy and flags come from registered state only.
  assign ram_cnt = wptr - rptr;
  assign o_full  = (ram_cnt == PTR_W'(DEPTH));
  assign o_count = ram_cnt + PTR_W'(head_vld);
  assign o_empty = (o_count == '0);

  assign o_s_ready = !o_full && !i_rst && !i_flush;
  assign push      = i_s_valid && o_s_ready;
  assign o_m_valid = head_vld;
  assign pop       = head_vld && i_m_ready;
  // Refill the memory output register only when it is free or being consumed this cycle.
  assign rd_en     = (ram_cnt != '0) && (!head_vld || pop) && !i_flush;

  assign o_m_data      = i_mem_rd_data;
  assign o_mem_wr_en   = push;
  assign o_mem_wr_addr = i_flush ? '0 : wptr[ADDR_WIDTH-1:0];
  assign o_mem_wr_data = i_flush ? '0 : i_s_data;
  assign o_mem_rd_en   = rd_en;
  assign o_mem_rd_addr = i_flush ? '0 : rptr[ADDR_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wptr     <= '0;
      rptr     <= '0;
      head_vld <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (rd_en) begin
        rptr     <= rptr + PTR_W'(1);
        head_vld <= 1'b1;
      end else if (pop) begin
        head_vld <= 1'b0;
      end
    end
  end

`ifdef FIFO_CTRL_WATERMARK_EN
  // Watermarks lag o_count by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      o_almost_full  <= (o_count >= PTR_W'(AF_LEVEL));
      o_almost_empty <= (o_count <= PTR_W'(AE_LEVEL));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized self-checking bench for fifo_ctrl with a queue-level reference model and memory model.
module tb_fifo_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned AF    = 4;
  localparam int unsigned AE    = 1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
`ifdef FIFO_CTRL_WATERMARK_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_s_valid     (s_valid),
    .o_s_ready     (s_ready),
    .i_s_data      (s_data),
    .o_m_valid     (m_valid),
    .i_m_ready     (m_ready),
    .o_m_data      (m_data),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_wr_addr (mem_wr_addr),
    .o_mem_wr_data (mem_wr_data),
    .o_mem_rd_en   (mem_rd_en),
    .o_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_data (mem_rd_data),
    .o_count       (count),
    .o_full        (full),
`ifdef FIFO_CTRL_WATERMARK_EN
    .o_almost_full (almost_full),
    .o_almost_empty(almost_empty),
`endif
    .o_empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage: registered read, output held while rd_en is low.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Reference model: words waiting in RAM plus an optional head word.
  logic [DW-1:0] ram_q[$];
  bit            hv;
  logic [DW-1:0] hd;
  bit            af_m;
  bit            ae_m;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input bit sv, input logic [DW-1:0] sd, input bit mr, input bit fl, input bit rs);
    int sz;
    int cnt;
    bit exp_rdy;
    bit exp_push;
    bit exp_pop;
    bit exp_fetch;
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    rst     = rs;
    #1;
    sz        = ram_q.size();
    cnt       = sz + int'(hv);
    exp_rdy   = (sz < int'(DEPTH)) && !rs && !fl;
    exp_push  = sv && exp_rdy;
    exp_pop   = hv && mr;
    exp_fetch = (sz != 0) && (!hv || exp_pop) && !fl;
    check_eq("s_ready", 64'(s_ready), 64'(exp_rdy));
    check_eq("m_valid", 64'(m_valid), 64'(hv));
    if (hv) check_eq("m_data", 64'(m_data), 64'(hd));
    check_eq("count", 64'(count), 64'(cnt));
    check_eq("full", 64'(full), 64'(sz == int'(DEPTH)));
    check_eq("empty", 64'(empty), 64'(cnt == 0));
    check_eq("mem_wr_en", 64'(mem_wr_en), 64'(exp_push));
    check_eq("mem_rd_en", 64'(mem_rd_en), 64'(exp_fetch));
`ifdef FIFO_CTRL_WATERMARK_EN
    check_eq("almost_full", 64'(almost_full), 64'(af_m));
    check_eq("almost_empty", 64'(almost_empty), 64'(ae_m));
`endif
    @(posedge clk);
    if (rs) begin
      af_m = 1'b0;
      ae_m = 1'b1;
    end else begin
      af_m = (cnt >= int'(AF));
      ae_m = (cnt <= int'(AE));
    end
    if (rs || fl) begin
      ram_q.delete();
      hv = 1'b0;
    end else begin
      if (exp_fetch) begin
        hd = ram_q.pop_front();
        hv = 1'b1;
      end else if (exp_pop) begin
        hv = 1'b0;
      end
      if (exp_push) ram_q.push_back(sd);
    end
  endtask

  initial begin
    int p_s;
    int p_m;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    hv = 1'b0; hd = '0; af_m = 1'b0; ae_m = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, then idle.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // Three words held, then drained back-to-back.
    step(1, 32'hA1, 0, 0, 0);
    step(1, 32'hA2, 0, 0, 0);
    step(1, 32'hA3, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    check_eq("count_three", 64'(count), 64'd3);
    check_eq("head_a1", 64'(m_data), 64'hA1);
    repeat (4) step(0, 0, 1, 0, 0);

    // Fill to capacity DEPTH+1 with the sink stalled, then free one slot.
    for (int i = 0; i < 8; i++) step(1, 32'hB0 + DW'(i), 0, 0, 0);
    check_eq("full_count", 64'(count), 64'(DEPTH + 1));
    step(1, 32'hBF, 1, 0, 0);
    repeat (3) step(1, 32'hC0, 0, 0, 0);
    repeat (8) step(0, 0, 1, 0, 0);

    // Flush with three words stored; next word is first out.
    for (int i = 0; i < 3; i++) step(1, 32'hD0 + DW'(i), 0, 0, 0);
    step(1, 32'hDD, 0, 1, 0);
    step(1, 32'h55, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);

    // Same with reset.
    for (int i = 0; i < 3; i++) step(1, 32'hE0 + DW'(i), 0, 0, 0);
    step(1, 32'hEE, 1, 0, 1);
    step(1, 32'h55, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);

    // Continuous stream.
    for (int i = 0; i < 100; i++) step(1, DW'(i), 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);

    // Sink toggling ready every cycle with continuous input.
    for (int i = 0; i < 60; i++) step(1, 32'h1000 + DW'(i), 1'(i & 1), 0, 0);
    repeat (8) step(0, 0, 1, 0, 0);

    // Random traffic in phases of differing pressure.
    for (int ph = 0; ph < 4; ph++) begin
      p_s = 30 + ph * 20;
      p_m = 90 - ph * 25;
      for (int i = 0; i < 500; i++)
        step(($urandom % 100) < p_s, $urandom, ($urandom % 100) < p_m,
             ($urandom % 40) == 0, ($urandom % 97) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
